dual_port_ecc_ram_latency: RTL and testbench

//  Dual-port RAM with per-port write/read pipeline latencies and Hamming(12,8) SEC protection.

---
 rtl/dual_port_ecc_ram_latency.sv | 195 +++++++++++++++++++
 tb/tb_dual_port_ecc_ram_latency.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ecc_ram_latency.sv
// Two-port scratch RAM with Hamming(12,8) SEC per word; writes commit WRITE_LATENCY_x edges after the request,
// read results appear READ_LATENCY_x edges after the request; fully pipelined, no backpressure or stalls.

module dp_ecc_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);
  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] dat_q;

  // Only the valid bits are reset; payload is don't-care while invalid.
  if (DEPTH > 1) begin : g_shift
    always_ff @(posedge i_clk) begin
      if (i_rst) vld_q <= '0;
      else       vld_q <= {vld_q[DEPTH-2:0], in_vld};
    end
    always_ff @(posedge i_clk) begin
      dat_q <= {dat_q[DEPTH-2:0], in_dat};
    end
  end else begin : g_single
    always_ff @(posedge i_clk) begin
      if (i_rst) vld_q <= '0;
      else       vld_q <= in_vld;
    end
    always_ff @(posedge i_clk) begin
      dat_q <= in_dat;
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];
endmodule

module dual_port_ecc_ram_latency #(
  parameter int ADDR_WIDTH      = 3,
  parameter int WRITE_LATENCY_A = 5,
  parameter int READ_LATENCY_A  = 4,
  parameter int WRITE_LATENCY_B = 4,
  parameter int READ_LATENCY_B  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en_a,
  input  logic                  i_we_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [7:0]            i_din_a,
  input  logic [11:0]           i_inj_a,
  output logic [7:0]            o_dout_a,
  output logic                  o_valid_a,
  output logic                  o_err_a,
  output logic                  o_corr_a,
  input  logic                  i_en_b,
  input  logic                  i_we_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [7:0]            i_din_b,
  input  logic [11:0]           i_inj_b,
  output logic [7:0]            o_dout_b,
  output logic                  o_valid_b,
  output logic                  o_err_b,
  output logic                  o_corr_b
);
  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic [7:0] dat;
    logic       err;
    logic       corr;
  } dec_t;

  // Codeword bit i is Hamming position i+1; parity lives at positions 1,2,4,8.
  function automatic logic [11:0] ecc_encode(input logic [7:0] d);
    logic [11:0] cw;
    cw     = '0;
    cw[2]  = d[0];
    cw[4]  = d[1];
    cw[5]  = d[2];
    cw[6]  = d[3];
    cw[8]  = d[4];
    cw[9]  = d[5];
    cw[10] = d[6];
    cw[11] = d[7];
    cw[0]  = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10];
    cw[1]  = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10];
    cw[3]  = cw[4] ^ cw[5] ^ cw[6] ^ cw[11];
    cw[7]  = cw[8] ^ cw[9] ^ cw[10] ^ cw[11];
    return cw;
  endfunction

  function automatic dec_t ecc_decode(input logic [11:0] cw_in);
    logic [11:0] cw;
    logic [3:0]  syn;
    dec_t        r;
    cw     = cw_in;
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6] ^ cw[11];
    syn[3] = cw[7] ^ cw[8] ^ cw[9] ^ cw[10] ^ cw[11];
    r.err  = (syn != 4'd0);
    r.corr = (syn != 4'd0) && (syn <= 4'd12);
    // Syndromes 13..15 point outside the word: report, but leave data as stored.
    if (r.corr) cw[syn - 4'd1] = ~cw[syn - 4'd1];
    r.dat  = {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
    return r;
  endfunction

  logic [11:0] mem [MEM_DEPTH];

  logic                     wa_vld, wb_vld, ra_vld, rb_vld;
  logic [ADDR_WIDTH+11:0]   wa_dat, wb_dat;
  logic [11:0]              ra_cw, rb_cw;
  dec_t                     dec_a, dec_b;

  dp_ecc_delay #(.DEPTH(WRITE_LATENCY_A), .W(ADDR_WIDTH + 12)) u_wr_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .in_vld  (i_en_a & i_we_a),
    .in_dat  ({i_addr_a, ecc_encode(i_din_a) ^ i_inj_a}),
    .out_vld (wa_vld),
    .out_dat (wa_dat)
  );

  dp_ecc_delay #(.DEPTH(WRITE_LATENCY_B), .W(ADDR_WIDTH + 12)) u_wr_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .in_vld  (i_en_b & i_we_b),
    .in_dat  ({i_addr_b, ecc_encode(i_din_b) ^ i_inj_b}),
    .out_vld (wb_vld),
    .out_dat (wb_dat)
  );

  // The array is sampled at the request edge, so reads see pre-commit contents.
  dp_ecc_delay #(.DEPTH(READ_LATENCY_A), .W(12)) u_rd_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .in_vld  (i_en_a & ~i_we_a),
    .in_dat  (mem[i_addr_a]),
    .out_vld (ra_vld),
    .out_dat (ra_cw)
  );

  dp_ecc_delay #(.DEPTH(READ_LATENCY_B), .W(12)) u_rd_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .in_vld  (i_en_b & ~i_we_b),
    .in_dat  (mem[i_addr_b]),
    .out_vld (rb_vld),
    .out_dat (rb_cw)
  );

  // Port A is written last so it wins a same-edge, same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wb_vld) mem[wb_dat[ADDR_WIDTH+11:12]] <= wb_dat[11:0];
      if (wa_vld) mem[wa_dat[ADDR_WIDTH+11:12]] <= wa_dat[11:0];
    end
  end

  assign dec_a = ecc_decode(ra_cw);
  assign dec_b = ecc_decode(rb_cw);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dout_a  <= '0;
      o_valid_a <= 1'b0;
      o_err_a   <= 1'b0;
      o_corr_a  <= 1'b0;
      o_dout_b  <= '0;
      o_valid_b <= 1'b0;
      o_err_b   <= 1'b0;
      o_corr_b  <= 1'b0;
    end else begin
      o_valid_a <= ra_vld;
      o_valid_b <= rb_vld;
      if (ra_vld) begin
        o_dout_a <= dec_a.dat;
        o_err_a  <= dec_a.err;
        o_corr_a <= dec_a.corr;
      end
      if (rb_vld) begin
        o_dout_b <= dec_b.dat;
        o_err_b  <= dec_b.err;
        o_corr_b <= dec_b.corr;
      end
    end
  end
endmodule

// File: tb/tb_dual_port_ecc_ram_latency.sv
// Scoreboarded bench for dual_port_ecc_ram_latency: directed writes/reads, timing of results, ECC cases, reset.

module tb_dual_port_ecc_ram_latency;
  localparam int RL_A = 4;
  localparam int RL_B = 5;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        en_a, we_a, en_b, we_b;
  logic [2:0]  addr_a, addr_b;
  logic [7:0]  din_a, din_b;
  logic [11:0] inj_a, inj_b;
  logic [7:0]  o_dout_a, o_dout_b;
  logic        o_valid_a, o_err_a, o_corr_a;
  logic        o_valid_b, o_err_b, o_corr_b;

  dual_port_ecc_ram_latency dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en_a    (en_a),
    .i_we_a    (we_a),
    .i_addr_a  (addr_a),
    .i_din_a   (din_a),
    .i_inj_a   (inj_a),
    .o_dout_a  (o_dout_a),
    .o_valid_a (o_valid_a),
    .o_err_a   (o_err_a),
    .o_corr_a  (o_corr_a),
    .i_en_b    (en_b),
    .i_we_b    (we_b),
    .i_addr_b  (addr_b),
    .i_din_b   (din_b),
    .i_inj_b   (inj_b),
    .o_dout_b  (o_dout_b),
    .o_valid_b (o_valid_b),
    .o_err_b   (o_err_b),
    .o_corr_b  (o_corr_b)
  );

  always #5 i_clk = ~i_clk;

  int unsigned edge_cnt = 0;
  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int unsigned edge_no;
    logic [7:0]  dat;
    logic        err;
    logic        corr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_rd(input string port, input exp_t e, input logic [7:0] d,
                          input logic er, input logic co);
    vectors++;
    if (d !== e.dat || er !== e.err || co !== e.corr || edge_cnt != e.edge_no) begin
      miscompares++;
      $display("FAIL read_%s: got dat=%h err=%b corr=%b at edge %0d, want dat=%h err=%b corr=%b at edge %0d",
               port, d, er, co, edge_cnt, e.dat, e.err, e.corr, e.edge_no);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL read_A: unexpected result dat=%h at edge %0d, want none", o_dout_a, edge_cnt);
      end else check_rd("A", q_a.pop_front(), o_dout_a, o_err_a, o_corr_a);
    end
    if (o_valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL read_B: unexpected result dat=%h at edge %0d, want none", o_dout_b, edge_cnt);
      end else check_rd("B", q_b.pop_front(), o_dout_b, o_err_b, o_corr_b);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    we_a  = 1'b0;
    we_b  = 1'b0;
    inj_a = '0;
    inj_b = '0;
  endtask

  task automatic req_a(input logic we, input logic [2:0] addr, input logic [7:0] din, input logic [11:0] inj);
    en_a = 1'b1; we_a = we; addr_a = addr; din_a = din; inj_a = inj;
  endtask

  task automatic req_b(input logic we, input logic [2:0] addr, input logic [7:0] din, input logic [11:0] inj);
    en_b = 1'b1; we_b = we; addr_b = addr; din_b = din; inj_b = inj;
  endtask

  // Called right after the step that sampled the read request.
  task automatic exp_a(input logic [7:0] d, input logic e, input logic c);
    exp_t x;
    x.edge_no = edge_cnt + RL_A; x.dat = d; x.err = e; x.corr = c;
    q_a.push_back(x);
  endtask

  task automatic exp_b(input logic [7:0] d, input logic e, input logic c);
    exp_t x;
    x.edge_no = edge_cnt + RL_B; x.dat = d; x.err = e; x.corr = c;
    q_b.push_back(x);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && (q_a.size() != 0 || q_b.size() != 0); i++) step();
    check_val(name, q_a.size() + q_b.size(), 0);
  endtask

  task automatic check_outs_zero(input string name);
    check_val(name, {o_dout_a, o_valid_a, o_err_a, o_corr_a, o_dout_b, o_valid_b, o_err_b, o_corr_b}, 0);
  endtask

  initial begin
    i_rst = 1'b1;
    en_a = 0; we_a = 0; addr_a = 0; din_a = 0; inj_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; din_b = 0; inj_b = 0;
    step();
    step();
    check_outs_zero("reset_outputs");
    i_rst = 1'b0;
    step();

    // Plain write, then reads on both ports after commit.
    req_a(1'b1, 3'd3, 8'hA5, 12'h000);
    step();
    repeat (5) step();
    check_val("codeword_addr3", dut.mem[3], 12'hA27);
    req_a(1'b0, 3'd3, 8'h00, 12'h000);
    req_b(1'b0, 3'd3, 8'h00, 12'h000);
    step();
    exp_a(8'hA5, 1'b0, 1'b0);
    exp_b(8'hA5, 1'b0, 1'b0);
    drain("drain_t1");

    // Single-bit error at position 5 gets corrected.
    req_a(1'b1, 3'd2, 8'hA5, 12'h010);
    step();
    repeat (5) step();
    req_b(1'b0, 3'd2, 8'h00, 12'h000);
    step();
    exp_b(8'hA5, 1'b1, 1'b1);

    // Syndrome 13: flagged, not corrected; d4 stays flipped (A5 -> B5).
    req_a(1'b1, 3'd5, 8'hA5, 12'h108);
    step();
    repeat (5) step();
    req_a(1'b0, 3'd5, 8'h00, 12'h000);
    step();
    exp_a(8'hB5, 1'b1, 1'b0);
    drain("drain_t23");
    check_val("hold_A", {o_valid_a, o_dout_a, o_err_a, o_corr_a}, {1'b0, 8'hB5, 1'b1, 1'b0});

    // Read-before-write around the commit edge, back-to-back reads on B.
    req_a(1'b1, 3'd1, 8'h3C, 12'h000);
    step();
    repeat (3) step();
    req_b(1'b0, 3'd1, 8'h00, 12'h000);
    step();
    exp_b(8'h00, 1'b0, 1'b0);
    req_b(1'b0, 3'd1, 8'h00, 12'h000);
    step();
    exp_b(8'h00, 1'b0, 1'b0);
    req_b(1'b0, 3'd1, 8'h00, 12'h000);
    step();
    exp_b(8'h3C, 1'b0, 1'b0);
    drain("drain_t4");

    // Same-edge collision on addr4 (A wins); addr6 has B commit one edge later (B wins).
    req_a(1'b1, 3'd4, 8'h11, 12'h000);
    step();
    req_b(1'b1, 3'd4, 8'h22, 12'h000);
    step();
    req_a(1'b1, 3'd6, 8'h11, 12'h000);
    step();
    step();
    req_b(1'b1, 3'd6, 8'h22, 12'h000);
    step();
    repeat (6) step();
    req_a(1'b0, 3'd4, 8'h00, 12'h000);
    req_b(1'b0, 3'd6, 8'h00, 12'h000);
    step();
    exp_a(8'h11, 1'b0, 1'b0);
    exp_b(8'h22, 1'b0, 1'b0);
    drain("drain_t5");

    // Reset kills a pending write and a pending read, clears memory and outputs.
    req_a(1'b0, 3'd5, 8'h00, 12'h000);
    step();
    exp_a(8'hB5, 1'b1, 1'b0);
    step();
    req_a(1'b1, 3'd0, 8'h77, 12'h000);
    step();
    req_b(1'b0, 3'd3, 8'h00, 12'h000);
    step();
    step();
    i_rst = 1'b1;
    req_a(1'b1, 3'd0, 8'h55, 12'h000);
    step();
    check_outs_zero("outputs_in_reset_1");
    req_b(1'b0, 3'd3, 8'h00, 12'h000);
    step();
    check_outs_zero("outputs_in_reset_2");
    i_rst = 1'b0;
    repeat (6) step();
    check_outs_zero("outputs_after_reset");
    req_a(1'b0, 3'd0, 8'h00, 12'h000);
    req_b(1'b0, 3'd3, 8'h00, 12'h000);
    step();
    exp_a(8'h00, 1'b0, 1'b0);
    exp_b(8'h00, 1'b0, 1'b0);
    req_a(1'b0, 3'd5, 8'h00, 12'h000);
    step();
    exp_a(8'h00, 1'b0, 1'b0);
    drain("drain_t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
